// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed FIR: clears the sample history, accepts samples and
// steps one MAC per tap. Optional overrun monitor enabled by macro FIR_SEQ_OVERRUN_EN.
module fir_mac_sequencer #(
  parameter  int TAPS    = 32,
  parameter  int MAC_LAT = 2,
  localparam int AW      = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic          wr_zero,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] coef_addr,
  output logic          acc_en,
  output logic          acc_clr,
  output logic          acc_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
`ifdef FIR_SEQ_OVERRUN_EN
  ,
  output logic          overrun,
  output logic [7:0]    overrun_cnt
`endif
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_wp;
  logic [2:0]    r_drain_cnt;

  logic          w_in_ready;
  logic          w_wr_en;
  logic          w_wr_zero;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_coef_addr;
  logic          w_acc_en;
  logic          w_acc_clr;
  logic          w_acc_last;
  logic          w_out_valid;
  logic          w_busy;

  // State register; reset always lands in CLEAR so a pending result is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_cnt == AW'(TAPS - 1)) w_state_nxt = S_IDLE;
        else                             w_state_nxt = S_CLEAR;
      end
      S_IDLE: begin
        if (flush)         w_state_nxt = S_CLEAR;
        else if (in_valid) w_state_nxt = S_MAC;
        else               w_state_nxt = S_IDLE;
      end
      S_MAC: begin
        if (r_k == AW'(TAPS - 1)) w_state_nxt = (MAC_LAT > 0) ? S_DRAIN : S_OUT;
        else                      w_state_nxt = S_MAC;
      end
      S_DRAIN: begin
        if (r_drain_cnt == 3'(MAC_LAT - 1)) w_state_nxt = S_OUT;
        else                                w_state_nxt = S_DRAIN;
      end
      S_OUT: begin
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_OUT;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Counters; clear and tap counters wrap naturally because TAPS is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt   <= '0;
      r_k         <= '0;
      r_wp        <= '0;
      r_drain_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
          r_wp      <= '0;
          r_k       <= '0;
        end
        S_IDLE: begin
          r_clr_cnt <= '0;
          r_k       <= '0;
        end
        S_MAC: begin
          r_k         <= r_k + AW'(1);
          r_drain_cnt <= 3'd0;
          if (r_k == AW'(TAPS - 1)) r_wp <= r_wp + AW'(1);
          else                      r_wp <= r_wp;
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 3'd1;
        end
        S_OUT: begin
          r_drain_cnt <= 3'd0;
        end
        default: begin
          r_clr_cnt <= '0;
          r_k       <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state and counters.
  always_comb begin
    w_in_ready  = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_zero   = 1'b0;
    w_wr_addr   = '0;
    w_rd_addr   = '0;
    w_coef_addr = '0;
    w_acc_en    = 1'b0;
    w_acc_clr   = 1'b0;
    w_acc_last  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_zero = 1'b1;
        w_wr_addr = r_clr_cnt;
      end
      S_IDLE: begin
        w_busy     = 1'b0;
        w_in_ready = 1'b1;
        w_wr_en    = in_valid & ~flush;
        w_wr_addr  = r_wp;
      end
      S_MAC: begin
        w_acc_en    = 1'b1;
        w_coef_addr = r_k;
        w_rd_addr   = r_wp - r_k;
        w_acc_clr   = (r_k == '0);
        w_acc_last  = (r_k == AW'(TAPS - 1));
      end
      S_DRAIN: begin
        w_busy = 1'b1;
      end
      S_OUT: begin
        w_out_valid = 1'b1;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  // Reset overrides every output, including the cycle before the reset edge.
  assign in_ready  = w_in_ready  & ~rst;
  assign wr_en     = w_wr_en     & ~rst;
  assign wr_zero   = w_wr_zero   & ~rst;
  assign wr_addr   = rst ? '0 : w_wr_addr;
  assign rd_addr   = rst ? '0 : w_rd_addr;
  assign coef_addr = rst ? '0 : w_coef_addr;
  assign acc_en    = w_acc_en    & ~rst;
  assign acc_clr   = w_acc_clr   & ~rst;
  assign acc_last  = w_acc_last  & ~rst;
  assign out_valid = w_out_valid & ~rst;
  assign busy      = w_busy      & ~rst;

`ifdef FIR_SEQ_OVERRUN_EN
  logic       r_overrun;
  logic [7:0] r_overrun_cnt;

  // Sticky flag and saturating count of samples offered while not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun     <= 1'b0;
      r_overrun_cnt <= 8'd0;
    end else if (r_state == S_IDLE && flush) begin
      r_overrun     <= 1'b0;
      r_overrun_cnt <= 8'd0;
    end else if (r_state != S_CLEAR && in_valid && !w_in_ready) begin
      r_overrun <= 1'b1;
      if (r_overrun_cnt != 8'hFF) r_overrun_cnt <= r_overrun_cnt + 8'd1;
      else                        r_overrun_cnt <= r_overrun_cnt;
    end else begin
      r_overrun     <= r_overrun;
      r_overrun_cnt <= r_overrun_cnt;
    end
  end

  assign overrun     = r_overrun & ~rst;
  assign overrun_cnt = rst ? 8'd0 : r_overrun_cnt;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer at TAPS=32, MAC_LAT=2.
module tb_fir_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, wr_en, wr_zero, acc_en, acc_clr, acc_last, out_valid, busy;
  logic [4:0] wr_addr, rd_addr, coef_addr;
`ifdef FIR_SEQ_OVERRUN_EN
  logic       overrun;
  logic [7:0] overrun_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.TAPS(32), .MAC_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_zero(wr_zero), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .coef_addr(coef_addr), .acc_en(acc_en), .acc_clr(acc_clr), .acc_last(acc_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef FIR_SEQ_OVERRUN_EN
    , .overrun(overrun), .overrun_cnt(overrun_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, in_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr,
            acc_en, acc_clr, acc_last, out_valid, busy};
  endfunction

  // Expects to be entered with CLEAR starting on the next negedge.
  task automatic check_clear();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
      chk("clear", {in_ready, wr_en, wr_zero, acc_en, busy, 3'd0, wr_addr},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 5'(i)});
    end
    @(negedge clk); #1;
    chk("idle_after_clear", {in_ready, wr_en, busy}, {1'b1, 1'b0, 1'b0});
  endtask

  // One sample: accept, 32 MAC cycles, 2 drain cycles, OUT with optional stall.
  task automatic do_sample(input logic [4:0] wp, input logic hold_valid, input int stall);
    logic [4:0] kk;
    logic [4:0] ra;
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("accept", {in_ready, wr_en, wr_zero, 3'd0, wr_addr}, {1'b1, 1'b1, 1'b0, 3'd0, wp});
    for (int k = 0; k < 32; k++) begin
      @(negedge clk); in_valid = hold_valid; #1;
      kk = 5'(k);
      ra = wp - kk;
      chk("mac", {acc_en, acc_clr, acc_last, wr_en, in_ready, out_valid, busy, 1'b0, coef_addr, 3'd0, rd_addr},
          {1'b1, (k == 0), (k == 31), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, kk, 3'd0, ra});
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk); #1;
      chk("drain", {acc_en, acc_clr, acc_last, wr_en, in_ready, out_valid, busy},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; #1;
      chk("out_hold", {out_valid, in_ready, wr_en, acc_en}, {1'b1, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk); out_ready = 1'b1; in_valid = (stall == 0) ? hold_valid : 1'b0; #1;
    chk("out_release", {out_valid, in_ready, busy}, {1'b1, 1'b0, 1'b1});
`ifdef FIR_SEQ_OVERRUN_EN
    if (stall == 10) begin
      chk("overrun_flag", {31'd0, overrun}, 32'd1);
      chk("overrun_cnt", {24'd0, overrun_cnt}, 32'd10);
    end
`endif
  endtask

  initial begin
    // Two reset cycles: everything held at zero.
    @(negedge clk); in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1; #1;
    chk("rst_outs_1", all_outs(), 32'd0);
    @(negedge clk); #1;
    chk("rst_outs_2", all_outs(), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; #1;
    chk("clear_first", {wr_en, wr_zero, in_ready, wr_addr}, {1'b1, 1'b1, 1'b0, 5'd0});
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); #1;
      chk("clear", {wr_en, wr_zero, in_ready, wr_addr}, {1'b1, 1'b1, 1'b0, 5'(i)});
    end
    @(negedge clk); #1;
    chk("idle_in_ready", {in_ready, wr_en, busy}, {1'b1, 1'b0, 1'b0});

    // First sample with a 10-cycle result stall while samples are offered.
    do_sample(5'd0, 1'b0, 10);

    // Back-to-back samples at the minimum period; wp wraps after 32 samples.
    for (int n = 1; n <= 32; n++) begin
      do_sample(5'(n), 1'b1, 0);
    end

    // Flush and in_valid together in IDLE: no accept, full clear, wp back to 0.
    @(negedge clk); in_valid = 1'b1; flush = 1'b1; #1;
    chk("flush_no_accept", {in_ready, wr_en}, {1'b1, 1'b0});
    check_clear();
`ifdef FIR_SEQ_OVERRUN_EN
    chk("flush_overrun_cnt", {24'd0, overrun_cnt}, 32'd0);
`endif
    do_sample(5'd0, 1'b0, 0);

    // Reset in the middle of MAC at k=10.
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("accept_pre_rst", {wr_en, wr_addr}, {1'b1, 5'd1});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); in_valid = 1'b0; #1;
    end
    @(negedge clk); #1;
    chk("mac_k10", {acc_en, coef_addr}, {1'b1, 5'd10});
    rst = 1'b1; in_valid = 1'b1; #1;
    chk("rst_mid_mac", all_outs(), 32'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
    chk("clear_after_rst", {wr_en, wr_zero, wr_addr}, {1'b1, 1'b1, 5'd0});
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); #1;
      chk("clear_rst", {wr_en, wr_zero, in_ready, wr_addr}, {1'b1, 1'b1, 1'b0, 5'(i)});
    end
    @(negedge clk); #1;
    chk("idle_after_rst", {in_ready, busy}, {1'b1, 1'b0});
    do_sample(5'd0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
